count_seq_checker: RTL and testbench
====================================

COUNT_SEQ_CHECKER -- requirements
Module: count_seq_checker

Interface
REQ-001 Parameter LOCK_LEN, default 4: consecutive correct transitions required to enter LOCKED; legal range 1..15.
REQ-002 Parameter UNLOCK_ERRS, default 2: consecutive incorrect transitions in LOCKED that force return to SYNC; legal range 1..15.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  count_in is sampled this cycle when high.
REQ-006 count_in  input  3  count value from the upstream 3-bit up-counter.
REQ-007 clr  input  1  synchronous clear of err_cnt and wrap_cnt only.
REQ-008 locked  output  1  high while FSM is in LOCKED; registered.
REQ-009 err_pulse  output  1  one-cycle pulse per sequence error detected in LOCKED.
REQ-010 err_cnt  output  8  saturating count of errors detected in LOCKED.
REQ-011 wrap_cnt  output  8  count of correct 7->0 transitions; present only with the macro (REQ-030).
REQ-012 state  output  2  FSM state encoding: IDLE=0, SYNC=1, LOCKED=2; value 3 is never produced.

Function
REQ-013 The expected successor of the previous sample prev SHALL be (prev+1) mod 8, so 7->0 is correct.
REQ-014 In IDLE, in_valid=1 SHALL load prev=count_in, set good_run=0 and move to SYNC; no check is made.
REQ-015 In SYNC, a correct sample SHALL increment good_run; on the sample where good_run reaches LOCK_LEN the FSM SHALL move to LOCKED with bad_run=0.
REQ-016 In SYNC, an incorrect sample SHALL clear good_run, stay in SYNC, and produce no err_pulse and no err_cnt change.
REQ-017 In LOCKED, a correct sample SHALL clear bad_run and stay in LOCKED.
REQ-018 In LOCKED, an incorrect sample SHALL:
- assert err_pulse in the next cycle;
- increment err_cnt, saturating at 255;
- increment bad_run.
REQ-019 When bad_run reaches UNLOCK_ERRS, the FSM SHALL move to SYNC with good_run=0; that final error is still counted and pulsed.
REQ-020 Every valid sample outside IDLE SHALL update prev to count_in, whether correct or not (resynchronise on the new value).
REQ-021 in_valid=0 SHALL hold prev, good_run, bad_run, state and counters unchanged, and err_pulse SHALL be 0 that cycle.
REQ-022 All outputs SHALL be registered; locked, state, err_pulse and err_cnt SHALL reflect a sample one cycle after the edge that captured it.
REQ-023 err_pulse SHALL never stay high for two cycles unless two consecutive valid samples are both errors in LOCKED.
REQ-024 When clr and a counted event occur in the same cycle, clr SHALL win: the counter becomes 0 and err_pulse is still asserted.
REQ-025 clr SHALL NOT affect state, prev, good_run or bad_run.

Reset
REQ-026 rst=1 at a clock edge SHALL set state=IDLE, locked=0, err_pulse=0, err_cnt=0, wrap_cnt=0, prev=0, good_run=0 and bad_run=0.
REQ-027 rst SHALL take priority over in_valid and clr.
REQ-028 rst mid-sequence SHALL discard lock status; the first valid sample after reset only loads prev.
REQ-029 No output SHALL depend combinationally on rst.

Configuration
REQ-030 Macro COUNT_SEQ_WRAP_CNT_EN:
- Defined: wrap_cnt SHALL increment modulo 256 on every correct 7->0 transition in SYNC or LOCKED.
- Undefined: the wrap counter logic SHALL be omitted and wrap_cnt SHALL be driven constant 0.
- The port exists in both builds.

Verification
REQ-031 Reset, then valid stream 0,1,2,3,4 -> state IDLE->SYNC; locked=1 one cycle after sample 4 is clocked; err_cnt=0.
REQ-032 Locked with prev=5, feed 5,6,7 -> one err_pulse after the first 5; err_cnt=1; second 5 restarts the successor chain; state stays LOCKED.
REQ-033 Locked, feed two consecutive bad samples 3,3,3 (after prev=3) -> two err_pulses, err_cnt=2, state=SYNC, locked=0; then four correct samples relock.
REQ-034 Locked stream with in_valid gaps (valid 6, idle 3 cycles, valid 7, valid 0) -> no errors; wrap_cnt=1 with macro and 0 without it.
REQ-035 Force 300 errors in LOCKED with UNLOCK_ERRS=15 and periodic relock -> err_cnt saturates at 255; assert clr in the same cycle as an error -> err_cnt=0 and err_pulse=1.
REQ-036 Assert rst while LOCKED with err_cnt=7 -> next cycle all outputs 0 and state=IDLE; next valid sample produces no pulse.

Source files
------------

// File: rtl/count_seq_checker.sv
// count_seq_checker: watches a 3-bit up-counter stream and tracks sync quality.
// IDLE loads the first sample. SYNC counts consecutive correct successors until
// LOCK_LEN is reached. LOCKED counts and pulses sequence errors, and falls back
// to SYNC after UNLOCK_ERRS consecutive errors.
// Optional feature macro: COUNT_SEQ_WRAP_CNT_EN (enables the 7->0 wrap counter).
module count_seq_checker #(
  parameter int LOCK_LEN    = 4,
  parameter int UNLOCK_ERRS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [2:0] count_in,
  input  logic       clr,
  output logic       locked,
  output logic       err_pulse,
  output logic [7:0] err_cnt,
  output logic [7:0] wrap_cnt,
  output logic [1:0] state
);

  localparam logic [3:0] LOCK_C   = 4'(LOCK_LEN);
  localparam logic [3:0] UNLOCK_C = 4'(UNLOCK_ERRS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } st_t;

  st_t        st_q, st_d;
  logic [2:0] prev_q, prev_d;
  logic [3:0] good_q, good_d;
  logic [3:0] bad_q, bad_d;
  logic       correct;
  logic       err_evt;

  logic       locked_q, locked_d;
  logic       pulse_q, pulse_d;
  logic [7:0] err_q, err_d;

  // A sample is correct when it is the mod-8 successor of the previous one.
  assign correct = (count_in == 3'(prev_q + 3'd1));

  // State register: FSM state and sequence-tracking context.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= IDLE;
      prev_q <= '0;
      good_q <= '0;
      bad_q  <= '0;
    end else begin
      st_q   <= st_d;
      prev_q <= prev_d;
      good_q <= good_d;
      bad_q  <= bad_d;
    end
  end

  // Next-state logic: nothing moves on idle cycles; every valid sample resyncs prev.
  always_comb begin
    st_d    = st_q;
    prev_d  = prev_q;
    good_d  = good_q;
    bad_d   = bad_q;
    err_evt = 1'b0;
    if (in_valid) begin
      prev_d = count_in;
      case (st_q)
        IDLE: begin
          good_d = '0;
          st_d   = SYNC;
        end
        SYNC: begin
          if (correct) begin
            good_d = 4'(good_q + 4'd1);
            if (4'(good_q + 4'd1) == LOCK_C) begin
              st_d  = LOCKED;
              bad_d = '0;
            end
          end else begin
            good_d = '0;
          end
        end
        LOCKED: begin
          if (correct) begin
            bad_d = '0;
          end else begin
            err_evt = 1'b1;
            bad_d   = 4'(bad_q + 4'd1);
            if (4'(bad_q + 4'd1) == UNLOCK_C) begin
              st_d   = SYNC;
              good_d = '0;
            end
          end
        end
        default: st_d = IDLE;
      endcase
    end
  end

  // Output logic: next values of the registered outputs; clr beats an increment.
  always_comb begin
    locked_d = (st_d == LOCKED);
    pulse_d  = err_evt;
    err_d    = err_q;
    if (err_evt && (err_q != 8'hFF)) err_d = 8'(err_q + 8'd1);
    if (clr) err_d = '0;
  end

  // Output registers, so nothing downstream sees combinational paths.
  always_ff @(posedge clk) begin
    if (rst) begin
      locked_q <= 1'b0;
      pulse_q  <= 1'b0;
      err_q    <= '0;
    end else begin
      locked_q <= locked_d;
      pulse_q  <= pulse_d;
      err_q    <= err_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = pulse_q;
  assign err_cnt   = err_q;
  assign state     = st_q;

`ifdef COUNT_SEQ_WRAP_CNT_EN
  logic [7:0] wrap_q, wrap_d;
  logic       wrap_evt;

  assign wrap_evt = in_valid && (st_q != IDLE) && correct && (prev_q == 3'd7);

  // Wrap counter next value: free-running mod 256, cleared by clr.
  always_comb begin
    wrap_d = wrap_q;
    if (wrap_evt) wrap_d = 8'(wrap_q + 8'd1);
    if (clr) wrap_d = '0;
  end

  // Wrap counter register.
  always_ff @(posedge clk) begin
    if (rst) wrap_q <= '0;
    else     wrap_q <= wrap_d;
  end

  assign wrap_cnt = wrap_q;
`else
  assign wrap_cnt = '0;
`endif

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed bench for count_seq_checker. Main instance uses default parameters;
// a second instance with UNLOCK_ERRS=15 shares the inputs for the saturation test.
module tb_count_seq_checker;

`ifdef COUNT_SEQ_WRAP_CNT_EN
  localparam int WRAP_EN = 1;
`else
  localparam int WRAP_EN = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [2:0] count_in = '0;
  logic       clr = 1'b0;

  logic       locked, err_pulse;
  logic [7:0] err_cnt, wrap_cnt;
  logic [1:0] state;
  logic       s_locked, s_err_pulse;
  logic [7:0] s_err_cnt, s_wrap_cnt;
  logic [1:0] s_state;

  int n_cmp = 0;
  int n_bad = 0;

  count_seq_checker u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .count_in(count_in), .clr(clr),
    .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt),
    .wrap_cnt(wrap_cnt), .state(state)
  );

  count_seq_checker #(.LOCK_LEN(4), .UNLOCK_ERRS(15)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .count_in(count_in), .clr(clr),
    .locked(s_locked), .err_pulse(s_err_pulse), .err_cnt(s_err_cnt),
    .wrap_cnt(s_wrap_cnt), .state(s_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock with the given inputs; outputs are sampled 1ns after the edge.
  task automatic step(input logic v, input logic [2:0] c, input logic cl);
    in_valid = v; count_in = c; clr = cl;
    @(posedge clk); #1;
    in_valid = 1'b0; clr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 3'd0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b0, 3'd0, 1'b0);
    step(1'b0, 3'd0, 1'b0);
    rst = 1'b0;
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked: got %0d want 0", locked); end
    n_cmp++; if (err_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_pulse: got %0d want 0", err_pulse); end
    n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_errcnt: got %0d want 0", err_cnt); end
    n_cmp++; if (wrap_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_wrapcnt: got %0d want 0", wrap_cnt); end
  endtask

  task automatic test_lock();
    step(1'b1, 3'd0, 1'b0);
    n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL lock_sync_state: got %0d want 1", state); end
    step(1'b1, 3'd1, 1'b0);
    step(1'b1, 3'd2, 1'b0);
    step(1'b1, 3'd3, 1'b0);
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL lock_early: got %0d want 0", locked); end
    step(1'b1, 3'd4, 1'b0);
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL lock_locked: got %0d want 1", locked); end
    n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL lock_state: got %0d want 2", state); end
    n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL lock_errcnt: got %0d want 0", err_cnt); end
  endtask

  // prev=4 on entry: 5 ok, then 5 (err), 6, 7 recover from the new value.
  task automatic test_single_err();
    step(1'b1, 3'd5, 1'b0);
    n_cmp++; if (err_pulse !== 1'b0) begin n_bad++; $display("FAIL se_nopulse: got %0d want 0", err_pulse); end
    step(1'b1, 3'd5, 1'b0);
    n_cmp++; if (err_pulse !== 1'b1) begin n_bad++; $display("FAIL se_pulse: got %0d want 1", err_pulse); end
    n_cmp++; if (err_cnt !== 8'd1) begin n_bad++; $display("FAIL se_errcnt: got %0d want 1", err_cnt); end
    step(1'b1, 3'd6, 1'b0);
    n_cmp++; if (err_pulse !== 1'b0) begin n_bad++; $display("FAIL se_pulse_drop: got %0d want 0", err_pulse); end
    step(1'b1, 3'd7, 1'b0);
    n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL se_state: got %0d want 2", state); end
    n_cmp++; if (err_cnt !== 8'd1) begin n_bad++; $display("FAIL se_errcnt_hold: got %0d want 1", err_cnt); end
  endtask

  // prev=7 on entry: 0 (wrap),1,2,3 ok; 3,3 unlock; 3 in SYNC silent; 4..7 relock.
  task automatic test_unlock_relock();
    step(1'b1, 3'd0, 1'b0);
    step(1'b1, 3'd1, 1'b0);
    step(1'b1, 3'd2, 1'b0);
    step(1'b1, 3'd3, 1'b0);
    step(1'b1, 3'd3, 1'b0);
    n_cmp++; if (err_pulse !== 1'b1 || state !== 2'd2) begin n_bad++; $display("FAIL ul_first: got pulse=%0d state=%0d want 1/2", err_pulse, state); end
    step(1'b1, 3'd3, 1'b0);
    n_cmp++; if (err_pulse !== 1'b1) begin n_bad++; $display("FAIL ul_second_pulse: got %0d want 1", err_pulse); end
    n_cmp++; if (state !== 2'd1 || locked !== 1'b0) begin n_bad++; $display("FAIL ul_unlock: got state=%0d locked=%0d want 1/0", state, locked); end
    n_cmp++; if (err_cnt !== 8'd3) begin n_bad++; $display("FAIL ul_errcnt: got %0d want 3", err_cnt); end
    step(1'b1, 3'd3, 1'b0);
    n_cmp++; if (err_pulse !== 1'b0 || err_cnt !== 8'd3) begin n_bad++; $display("FAIL ul_sync_silent: got pulse=%0d cnt=%0d want 0/3", err_pulse, err_cnt); end
    step(1'b1, 3'd4, 1'b0);
    step(1'b1, 3'd5, 1'b0);
    step(1'b1, 3'd6, 1'b0);
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL ul_relock_early: got %0d want 0", locked); end
    step(1'b1, 3'd7, 1'b0);
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL ul_relock: got %0d want 1", locked); end
    n_cmp++; if (wrap_cnt !== 8'(WRAP_EN)) begin n_bad++; $display("FAIL ul_wrap: got %0d want %0d", wrap_cnt, WRAP_EN); end
  endtask

  task automatic test_gaps();
    do_reset();
    for (int i = 1; i <= 5; i++) step(1'b1, 3'(i), 1'b0);
    step(1'b1, 3'd6, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 3'd2, 1'b0);
    n_cmp++; if (err_pulse !== 1'b0 || state !== 2'd2) begin n_bad++; $display("FAIL gap_hold: got pulse=%0d state=%0d want 0/2", err_pulse, state); end
    step(1'b1, 3'd7, 1'b0);
    step(1'b1, 3'd0, 1'b0);
    n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL gap_errcnt: got %0d want 0", err_cnt); end
    n_cmp++; if (wrap_cnt !== 8'(WRAP_EN)) begin n_bad++; $display("FAIL gap_wrap: got %0d want %0d", wrap_cnt, WRAP_EN); end
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL gap_locked: got %0d want 1", locked); end
  endtask

  // Checked on u_sat: blocks of 14 errors then one correct sample keep it LOCKED.
  task automatic test_saturate_clr();
    logic [2:0] c;
    do_reset();
    for (int i = 0; i <= 4; i++) step(1'b1, 3'(i), 1'b0);
    c = 3'd4;
    for (int b = 0; b < 22; b++) begin
      for (int e = 0; e < 14; e++) step(1'b1, c, 1'b0);
      c = 3'(c + 3'd1);
      step(1'b1, c, 1'b0);
      if (b == 17) begin
        n_cmp++; if (s_err_cnt !== 8'd252) begin n_bad++; $display("FAIL sat_mid: got %0d want 252", s_err_cnt); end
      end
    end
    n_cmp++; if (s_err_cnt !== 8'd255) begin n_bad++; $display("FAIL sat_cap: got %0d want 255", s_err_cnt); end
    n_cmp++; if (s_state !== 2'd2) begin n_bad++; $display("FAIL sat_state: got %0d want 2", s_state); end
    step(1'b1, c, 1'b1);
    n_cmp++; if (s_err_cnt !== 8'd0 || s_err_pulse !== 1'b1) begin n_bad++; $display("FAIL sat_clr: got cnt=%0d pulse=%0d want 0/1", s_err_cnt, s_err_pulse); end
    n_cmp++; if (s_wrap_cnt !== 8'd0) begin n_bad++; $display("FAIL sat_clr_wrap: got %0d want 0", s_wrap_cnt); end
    step(1'b1, c, 1'b0);
    n_cmp++; if (s_err_cnt !== 8'd1) begin n_bad++; $display("FAIL sat_after_clr: got %0d want 1", s_err_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [2:0] c;
    do_reset();
    for (int i = 0; i <= 4; i++) step(1'b1, 3'(i), 1'b0);
    c = 3'd4;
    for (int k = 0; k < 7; k++) begin
      step(1'b1, c, 1'b0);
      c = 3'(c + 3'd1);
      step(1'b1, c, 1'b0);
    end
    n_cmp++; if (err_cnt !== 8'd7 || locked !== 1'b1) begin n_bad++; $display("FAIL rm_pre: got cnt=%0d locked=%0d want 7/1", err_cnt, locked); end
    n_cmp++; if (wrap_cnt !== 8'(WRAP_EN)) begin n_bad++; $display("FAIL rm_prewrap: got %0d want %0d", wrap_cnt, WRAP_EN); end
    rst = 1'b1;
    step(1'b1, 3'd5, 1'b1);
    rst = 1'b0;
    n_cmp++; if (state !== 2'd0 || locked !== 1'b0 || err_pulse !== 1'b0) begin n_bad++; $display("FAIL rm_rst: got state=%0d locked=%0d pulse=%0d want 0/0/0", state, locked, err_pulse); end
    n_cmp++; if (err_cnt !== 8'd0 || wrap_cnt !== 8'd0) begin n_bad++; $display("FAIL rm_rst_cnt: got err=%0d wrap=%0d want 0/0", err_cnt, wrap_cnt); end
    step(1'b1, 3'd6, 1'b0);
    n_cmp++; if (state !== 2'd1 || err_pulse !== 1'b0) begin n_bad++; $display("FAIL rm_first: got state=%0d pulse=%0d want 1/0", state, err_pulse); end
    step(1'b1, 3'd2, 1'b0);
    n_cmp++; if (state !== 2'd1 || err_pulse !== 1'b0 || err_cnt !== 8'd0) begin n_bad++; $display("FAIL rm_sync_bad: got state=%0d pulse=%0d cnt=%0d want 1/0/0", state, err_pulse, err_cnt); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_single_err();
    test_unlock_relock();
    test_gaps();
    test_saturate_clr();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
